// File: rtl/unsigned_mul_8x8_ha_array_reducer_if.sv
// Handshake bundle between the ha_array generator, the row reducer and the product consumer.
// Upstream side: s_valid/s_ready with 4 carry rows and 4 sum rows. Downstream side: m_valid/m_ready with p/ovf.
interface unsigned_mul_8x8_ha_array_reducer_if;
    logic        s_valid;
    logic        s_ready;
    logic [6:0]  ha_array_0_b;
    logic [6:0]  ha_array_1_b;
    logic [6:0]  ha_array_2_b;
    logic [6:0]  ha_array_3_b;
    logic [8:0]  ha_array_0_t;
    logic [8:0]  ha_array_1_t;
    logic [8:0]  ha_array_2_t;
    logic [8:0]  ha_array_3_t;
    logic [15:0] p;
    logic        ovf;
    logic        m_valid;
    logic        m_ready;

    modport slave (
        input  s_valid,
        input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
        input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
        input  m_ready,
        output s_ready,
        output p,
        output ovf,
        output m_valid
    );

    modport master (
        output s_valid,
        output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
        output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
        output m_ready,
        input  s_ready,
        input  p,
        input  ovf,
        input  m_valid
    );
endinterface

// File: rtl/unsigned_mul_8x8_ha_array_reducer.sv
// Sums the four ha_array rows one per cycle into a 16-bit product; result valid 5 cycles after accept.
// Result held in DONE until m_ready; a new bundle may be accepted on the same edge the result is consumed.
module unsigned_mul_8x8_ha_array_reducer (
    input  logic                                clk,
    input  logic                                rst,
    unsigned_mul_8x8_ha_array_reducer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [8:0]  r_t [4];
    logic [6:0]  r_b [4];
    logic [15:0] r_acc;
    logic        r_ovf;

    logic        w_s_ready;
    logic        w_accept;
    logic [16:0] w_row;
    logic [16:0] w_sum;

    assign w_s_ready = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.m_ready));
    assign w_accept  = bus.s_valid && w_s_ready;

    // Row k: sum row at weight 4^k, carry row two bit positions above it.
    always_comb begin
        w_row = 17'd0;
        case (r_cnt)
            2'd0:    w_row = {8'd0, r_t[0]}       + {8'd0, r_b[0], 2'b00};
            2'd1:    w_row = {6'd0, r_t[1], 2'b00} + {6'd0, r_b[1], 4'b0000};
            2'd2:    w_row = {4'd0, r_t[2], 4'b0000} + {4'd0, r_b[2], 6'b000000};
            default: w_row = {2'd0, r_t[3], 6'b000000} + {2'd0, r_b[3], 8'b00000000};
        endcase
    end

    // Largest row plus a full accumulator still fits in 17 bits, so bit 16 is the carry out of bit 15.
    assign w_sum = {1'b0, r_acc} + w_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_acc   <= 16'd0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_t[k] <= 9'd0;
                r_b[k] <= 7'd0;
            end
        end else if (w_accept) begin
            r_t[0]  <= bus.ha_array_0_t;
            r_t[1]  <= bus.ha_array_1_t;
            r_t[2]  <= bus.ha_array_2_t;
            r_t[3]  <= bus.ha_array_3_t;
            r_b[0]  <= bus.ha_array_0_b;
            r_b[1]  <= bus.ha_array_1_b;
            r_b[2]  <= bus.ha_array_2_b;
            r_b[3]  <= bus.ha_array_3_b;
            r_acc   <= 16'd0;
            r_ovf   <= 1'b0;
            r_cnt   <= 2'd0;
            r_state <= S_ACC;
        end else begin
            case (r_state)
                S_ACC: begin
                    r_acc <= w_sum[15:0];
                    r_ovf <= r_ovf | w_sum[16];
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.m_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = (r_state == S_DONE);
    assign bus.p       = r_acc;
    assign bus.ovf     = r_ovf;
endmodule
